// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        REQ        = 2'd1,
        HOLD       = 2'd2,
        DRAIN      = 2'd3
    } fetch_state_t;

    // Every instruction occupies one aligned 4-byte word.
    localparam int INSTR_BYTES = 4;

    // Value shown on the instruction bus before the first fetch lands.
    localparam int RESET_INSTR = 0;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's redirect, memory and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: i_stall_d holds the IF/ID stage; the memory side is req/ack.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int PC_WIDTH     = 10,
    parameter int P_CNT_WIDTH  = 16
);
    logic                    i_stall_d;
    logic                    i_pcsrc_e;
    logic [PC_WIDTH:0]       i_pctarget_e;
    logic                    o_mem_req;
    logic [PC_WIDTH:0]       o_mem_addr;
    logic                    i_mem_ack;
    logic [P_DATA_WIDTH-1:0] i_mem_rdata;
    logic                    o_valid_f;
    logic [P_DATA_WIDTH-1:0] o_instr_f;
    logic [PC_WIDTH:0]       o_pc_f;
    logic [PC_WIDTH:0]       o_pc4_f;
    logic                    o_busy_f;
    logic [P_CNT_WIDTH-1:0]  o_wait_cnt;

    // The fetch sequencer side.
    modport master (
        input  i_stall_d, i_pcsrc_e, i_pctarget_e, i_mem_ack, i_mem_rdata,
        output o_mem_req, o_mem_addr, o_valid_f, o_instr_f, o_pc_f, o_pc4_f,
               o_busy_f, o_wait_cnt
    );

    // The surrounding pipeline / memory side.
    modport slave (
        output i_stall_d, i_pcsrc_e, i_pctarget_e, i_mem_ack, i_mem_rdata,
        input  o_mem_req, o_mem_addr, o_valid_f, o_instr_f, o_pc_f, o_pc4_f,
               o_busy_f, o_wait_cnt
    );
endinterface

// File: rtl/fetch_ctrl_pc_gen.sv
// Fetch PC register, pending redirect target register and the +4 adder.
// Latency: loads take effect on the next clock; fetch_pc4 is combinational.
// Backpressure: none; the sequencer only pulses loads when the PC may advance.
module fetch_ctrl_pc_gen
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int P_RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              load_next,
    input  logic              load_target,
    input  logic              latch_target,
    input  logic [PC_WIDTH:0] target,
    output logic [PC_WIDTH:0] fetch_pc,
    output logic [PC_WIDTH:0] fetch_pc4
);
    localparam logic [PC_WIDTH:0] ALIGN_MASK = ~((PC_WIDTH+1)'(INSTR_BYTES - 1));
    localparam logic [PC_WIDTH:0] RESET_PC   = (PC_WIDTH+1)'(P_RESET_PC) & ALIGN_MASK;
    localparam logic [PC_WIDTH:0] PC_STEP    = (PC_WIDTH+1)'(INSTR_BYTES);

    logic [PC_WIDTH:0] fetch_pc_q;
    logic [PC_WIDTH:0] target_q;
    logic [PC_WIDTH:0] target_aligned;
    logic [PC_WIDTH:0] pending_target;

    // A redirect arriving this cycle is newer than anything already latched.
    assign target_aligned = target & ALIGN_MASK;
    assign pending_target = latch_target ? target_aligned : target_q;
    assign fetch_pc       = fetch_pc_q;
    assign fetch_pc4      = fetch_pc_q + PC_STEP;

    // Target capture and PC update; a redirect load beats sequential advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            target_q   <= '0;
        end else begin
            if (latch_target) begin
                target_q <= target_aligned;
            end
            if (load_target) begin
                fetch_pc_q <= pending_target;
            end else if (load_next) begin
                fetch_pc_q <= fetch_pc4;
            end
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and walks a req/ack instruction memory port.
// Latency: o_valid_f rises the cycle after i_mem_ack; zero-wait memory gives 1 instr / 2 cycles.
// Backpressure: i_stall_d freezes the held instruction; redirects squash wrong-path fetches.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int PC_WIDTH     = 10,
    parameter int P_RESET_PC   = 0,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_ctrl_if.master  bus
);
    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);

    fetch_state_t      state;
    logic              load_next;
    logic              load_target;
    logic              latch_target;
    logic              mem_busy;
    logic [PC_WIDTH:0] fetch_pc;
    logic [PC_WIDTH:0] fetch_pc4;

    fetch_ctrl_pc_gen #(
        .PC_WIDTH   (PC_WIDTH),
        .P_RESET_PC (P_RESET_PC)
    ) u_pc_gen (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .load_next    (load_next),
        .load_target  (load_target),
        .latch_target (latch_target),
        .target       (bus.i_pctarget_e),
        .fetch_pc     (fetch_pc),
        .fetch_pc4    (fetch_pc4)
    );

    // The address stays on fetch_pc for the whole request, so it cannot move before ack.
    assign mem_busy       = (state == REQ) || (state == DRAIN);
    assign bus.o_mem_req  = mem_busy;
    assign bus.o_busy_f   = mem_busy;
    assign bus.o_mem_addr = fetch_pc;

    // PC control: which events move fetch_pc and when a redirect target is captured.
    always_comb begin
        load_next    = 1'b0;
        load_target  = 1'b0;
        latch_target = 1'b0;
        case (state)
            REQ: begin
                latch_target = bus.i_pcsrc_e;
                load_target  = bus.i_mem_ack & bus.i_pcsrc_e;
            end
            HOLD: begin
                latch_target = bus.i_pcsrc_e;
                load_target  = bus.i_pcsrc_e;
                load_next    = ~bus.i_pcsrc_e & ~bus.i_stall_d;
            end
            DRAIN: begin
                latch_target = bus.i_pcsrc_e;
                load_target  = bus.i_mem_ack;
            end
            default: ;
        endcase
    end

    // Sequencer state, the IF/ID holding registers and the saturating wait counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= RESET_WAIT;
            bus.o_valid_f  <= 1'b0;
            bus.o_instr_f  <= P_DATA_WIDTH'(RESET_INSTR);
            bus.o_pc_f     <= '0;
            bus.o_pc4_f    <= '0;
            bus.o_wait_cnt <= '0;
        end else begin
            if (mem_busy && (bus.o_wait_cnt != '1)) begin
                bus.o_wait_cnt <= bus.o_wait_cnt + CNT_ONE;
            end
            case (state)
                RESET_WAIT: state <= REQ;
                REQ: begin
                    if (bus.i_mem_ack) begin
                        if (!bus.i_pcsrc_e) begin
                            bus.o_valid_f <= 1'b1;
                            bus.o_instr_f <= bus.i_mem_rdata;
                            bus.o_pc_f    <= fetch_pc;
                            bus.o_pc4_f   <= fetch_pc4;
                            state         <= HOLD;
                        end
                    end else if (bus.i_pcsrc_e) begin
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (bus.i_pcsrc_e || !bus.i_stall_d) begin
                        bus.o_valid_f <= 1'b0;
                        state         <= REQ;
                    end
                end
                DRAIN: begin
                    if (bus.i_mem_ack) begin
                        state <= REQ;
                    end
                end
                default: state <= RESET_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed stimulus for fetch_ctrl with a queue-based scoreboard.
// Latency: expects each delivered instruction one cycle after its accepted ack.
// Backpressure: stall and redirect are driven randomly alongside memory latency.
module tb_fetch_ctrl;
    localparam int PCW     = 10;
    localparam int DW      = 32;
    localparam int CW      = 16;
    localparam int PC_MOD  = 1 << (PCW + 1);
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] instr;
        int            pc;
        int            pc4;
        int            stamp;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    fetch_ctrl_if #(.P_DATA_WIDTH(DW), .PC_WIDTH(PCW), .P_CNT_WIDTH(CW)) bus ();

    fetch_ctrl #(
        .P_DATA_WIDTH (DW),
        .PC_WIDTH     (PCW),
        .P_RESET_PC   (0),
        .P_CNT_WIDTH  (CW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state: the architectural instruction stream, not the FSM.
    logic [DW-1:0] mem_img [512];
    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_pc = 0;
    int   model_wait = 0;
    bit   squashed = 0;
    bit   exp_inv = 0;
    bit   last_req = 0;
    bit   last_ack = 0;
    int   last_addr = 0;
    bit   mon_prev_valid = 0;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input logic ack, input logic redir, input int tgt, input logic stall);
        logic req, valid, do_redir;
        int   addr;
        exp_t e;
        req   = bus.o_mem_req;
        valid = bus.o_valid_f;
        addr  = int'(bus.o_mem_addr);
        if (exp_inv) chk("valid_clear", valid, 0);
        if (last_req && !last_ack) begin
            chk("req_held", req, 1);
            chk("addr_stable", addr, last_addr);
        end
        do_redir         = redir && (req || valid);
        bus.i_mem_ack    = ack;
        bus.i_mem_rdata  = (ack && req) ? mem_img[addr >> 2] : $urandom();
        bus.i_pcsrc_e    = do_redir;
        bus.i_pctarget_e = (PCW+1)'(tgt);
        bus.i_stall_d    = stall;
        exp_inv = 0;
        if (req && model_wait < CNT_MAX) model_wait++;
        if (req && ack) begin
            if (!squashed && !do_redir) begin
                chk("req_addr", addr, next_pc);
                e.instr = mem_img[next_pc >> 2];
                e.pc    = next_pc;
                e.pc4   = (next_pc + 4) % PC_MOD;
                e.stamp = cyc;
                exp_q.push_back(e);
            end
            squashed = 0;
        end else if (req && do_redir) begin
            squashed = 1;
        end
        if (do_redir) begin
            next_pc = tgt - (tgt % 4);
            exp_inv = valid;
        end else if (valid && !stall) begin
            next_pc = (next_pc + 4) % PC_MOD;
            exp_inv = 1;
        end
        last_req  = req;
        last_ack  = ack;
        last_addr = addr;
        @(negedge i_clk);
    endtask

    // Reset pulse starting at a falling edge; outputs must clear asynchronously.
    task automatic do_reset();
        i_rst_n          = 1'b0;
        bus.i_mem_ack    = 1'b0;
        bus.i_pcsrc_e    = 1'b0;
        bus.i_pctarget_e = '0;
        bus.i_stall_d    = 1'b0;
        bus.i_mem_rdata  = '0;
        #1;
        chk("rst_mem_req", bus.o_mem_req, 0);
        chk("rst_busy", bus.o_busy_f, 0);
        chk("rst_valid", bus.o_valid_f, 0);
        chk("rst_instr", bus.o_instr_f, 0);
        chk("rst_pc", bus.o_pc_f, 0);
        chk("rst_pc4", bus.o_pc4_f, 0);
        chk("rst_wait_cnt", bus.o_wait_cnt, 0);
        repeat (2) @(negedge i_clk);
        next_pc = 0; model_wait = 0; squashed = 0; exp_inv = 0;
        last_req = 0; last_ack = 0; last_addr = 0;
        exp_q.delete();
        i_rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented.
    always @(posedge i_clk) begin
        #1;
        if (!i_rst_n) begin
            mon_prev_valid = 0;
        end else begin
            chk("wait_cnt", bus.o_wait_cnt, model_wait);
            if (bus.o_valid_f && !mon_prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pc 0x%0h, expected no instruction", bus.o_pc_f);
                end else begin
                    cur = exp_q.pop_front();
                    chk("instr", bus.o_instr_f, cur.instr);
                    chk("pc", bus.o_pc_f, cur.pc);
                    chk("pc4", bus.o_pc4_f, cur.pc4);
                    chk("valid_latency", cyc, cur.stamp + 1);
                end
            end else if (bus.o_valid_f) begin
                chk("held_instr", bus.o_instr_f, cur.instr);
                chk("held_pc", bus.o_pc_f, cur.pc);
            end
            mon_prev_valid = bus.o_valid_f;
        end
    end

    initial begin
        int lat;
        for (int i = 0; i < 512; i++) mem_img[i] = $urandom();
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        do_reset();

        // Stray ack during the post-reset cycle, then zero-wait fetch of 0x000.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Three-cycle memory on 0x004.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wait_cnt_3cyc", bus.o_wait_cnt, 4);
        // Stall for four cycles in HOLD.
        for (int i = 0; i < 4; i++) begin
            chk("stall_no_req", bus.o_mem_req, 0);
            step(0, 0, 0, 1);
        end
        chk("stall_held_pc", bus.o_pc_f, 4);
        step(0, 0, 0, 0);
        chk("after_stall_req", bus.o_mem_req, 1);
        chk("after_stall_addr", bus.o_mem_addr, 8);
        // Redirect to 0x120 then 0x200 while 0x008 is outstanding.
        step(0, 1, 'h120, 0);
        chk("drain_busy", bus.o_busy_f, 1);
        chk("drain_old_addr", bus.o_mem_addr, 8);
        step(0, 1, 'h200, 0);
        step(1, 0, 0, 0);
        chk("drain_no_valid", bus.o_valid_f, 0);
        chk("drain_new_addr", bus.o_mem_addr, 'h200);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Single redirect to 0x120 while 0x204 is outstanding.
        step(0, 1, 'h120, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("redir_addr_120", bus.o_mem_addr, 'h120);
        // Unaligned redirect while stalled in HOLD.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 'h0F3, 1);
        chk("hold_redir_valid", bus.o_valid_f, 0);
        chk("hold_redir_addr", bus.o_mem_addr, 'h0F0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Ack and redirect together, then PC wrap from 0x7FC.
        step(1, 1, 'h7FC, 0);
        chk("ack_redir_addr", bus.o_mem_addr, 'h7FC);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_addr", bus.o_mem_addr, 0);

        // Random traffic.
        lat = -1;
        for (int n = 0; n < 3000; n++) begin
            logic a, r, s;
            int   t;
            if (bus.o_mem_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                a = (lat == 0);
                if (a) lat = -1; else lat--;
            end else begin
                lat = -1;
                a = ($urandom_range(0, 3) == 0);
            end
            r = ($urandom_range(0, 11) == 0);
            t = $urandom_range(0, PC_MOD - 1);
            s = ($urandom_range(0, 2) == 0);
            step(a, r, t, s);
        end

        // Saturate the wait counter on a never-acked request.
        for (int i = 0; i < 10 && !bus.o_mem_req; i++) step(0, 0, 0, 0);
        chk("sat_req_reached", bus.o_mem_req, 1);
        for (int i = 0; i < CNT_MAX + 5; i++) step(0, 0, 0, 0);
        chk("wait_cnt_sat", bus.o_wait_cnt, CNT_MAX);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wait_cnt_sat_hold", bus.o_wait_cnt, CNT_MAX);

        // Reset in the middle of a drain.
        step(0, 1, 'h300, 0);
        chk("pre_reset_drain", bus.o_busy_f, 1);
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(bus.o_mem_req, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the RISC-V pipeline front end. It owns the program counter and drives a variable-latency instruction memory port through a req/ack handshake, so instruction storage can be slower than one cycle. Fetched instructions are presented to the IF/ID boundary with a valid flag. Branch redirects from execute are handled by discarding any in-flight or held instruction on the wrong path.

## Interface
Parameters:
- P_DATA_WIDTH, default 32: instruction width.
- PC_WIDTH, default 10: PC buses are [PC_WIDTH:0].
- P_RESET_PC, default 0: first fetch address after reset.
- P_CNT_WIDTH, default 16: width of the wait-cycle counter.

Ports:
- i_clk, input, 1: system clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_stall_d, input, 1: decode cannot accept this cycle.
- i_pcsrc_e, input, 1: redirect request from execute; one-cycle pulse.
- i_pctarget_e, input, PC_WIDTH+1: redirect target.
- o_mem_req, output, 1: memory request.
- o_mem_addr, output, PC_WIDTH+1: request address; bits [1:0] are always 0.
- i_mem_ack, input, 1: one-cycle pulse; i_mem_rdata is valid in the same cycle.
- i_mem_rdata, input, P_DATA_WIDTH: instruction word.
- o_valid_f, output, 1: o_instr_f, o_pc_f and o_pc4_f are valid.
- o_instr_f, output, P_DATA_WIDTH: held instruction.
- o_pc_f, output, PC_WIDTH+1: address of the held instruction.
- o_pc4_f, output, PC_WIDTH+1: o_pc_f + 4.
- o_busy_f, output, 1: a memory request is outstanding (state REQ or DRAIN).
- o_wait_cnt, output, P_CNT_WIDTH: count of cycles spent in REQ or DRAIN.

## Operation
States: RESET_WAIT, REQ, HOLD, DRAIN.
- **RESET_WAIT:** first cycle after reset is released. Goes unconditionally to REQ.
- **REQ:** o_mem_req=1 and o_mem_addr=fetch_pc.
  - On i_mem_ack without redirect: capture rdata into o_instr_f, fetch_pc into o_pc_f, and fetch_pc+4 into o_pc4_f; go to HOLD.
  - On i_mem_ack with redirect: drop rdata; fetch_pc=target; stay in REQ.
  - Redirect without ack: latch the target; go to DRAIN.
- **HOLD:** o_valid_f=1.
  - Redirect has priority: clear o_valid_f, set fetch_pc=target, go to REQ.
  - Otherwise, if i_stall_d=0 the instruction is consumed: fetch_pc=o_pc4_f, go to REQ.
  - If i_stall_d=1, stay in HOLD with all outputs frozen.
- **DRAIN:** o_mem_req=1 with the old address held.
  - A further redirect overwrites the latched target.
  - On i_mem_ack: drop rdata, load fetch_pc from the latched target, go to REQ. If a redirect coincides with the ack, that newer target is the one used.
- Handshake rule: once o_mem_req rises, o_mem_addr stays stable until the ack cycle inclusive. o_mem_req never deasserts before ack.
- Arithmetic: PC+4 wraps modulo 2^(PC_WIDTH+1). Target bits [1:0] are forced to 0.
- o_wait_cnt increments in every REQ or DRAIN cycle, including the ack cycle, and saturates at all-ones.
- i_mem_ack outside REQ/DRAIN is ignored.

## Timing
- Reset values:
  - State RESET_WAIT; fetch_pc = P_RESET_PC.
  - o_mem_req=0, o_valid_f=0, o_instr_f=0, o_pc_f=0, o_pc4_f=0, o_busy_f=0, o_wait_cnt=0.
- Reset mid-request: an ack arriving after reset deassertion while in RESET_WAIT is ignored.
- Zero-wait memory (ack in the request cycle): REQ→HOLD gives 1 instruction per 2 cycles.
- Latency: o_valid_f rises the cycle after the ack.
- Redirect timing:
  - Redirect in HOLD: o_valid_f is 0 the next cycle.
  - Redirect in REQ: the first request to the target is issued in the cycle after the redirect.
  - Redirect in DRAIN: the first request to the target is issued the cycle after the old ack.
- Outputs are registered except o_mem_req, o_mem_addr and o_busy_f, which are decoded from state and registers.

## Structure
- Package fetch_ctrl_pkg holds:
  - the state enum fetch_state_t;
  - INSTR_BYTES = 4;
  - the reset instruction value 0.
- Sub-module pc_gen: the fetch_pc register plus latched-target register, +4 adder, and alignment masking.
  - Inputs: load-next, load-target, latch-target.

## Test plan
- **Reset then zero-wait memory, i_stall_d=0:** requests to 0x000, 0x004, 0x008 on alternate cycles; o_valid_f pulses with matching o_pc_f and o_pc4_f.
- **3-cycle memory latency:** o_mem_req held with o_mem_addr=0x004 stable for 3 cycles; o_wait_cnt increments by 3 per fetch.
- **i_stall_d=1 for 4 cycles in HOLD:** o_instr_f and o_pc_f frozen, no new request; request to pc+4 the cycle after stall drops.
- **Redirect to 0x120 while waiting on 0x008:** DRAIN until ack, data dropped, o_valid_f stays 0; next request address 0x120. A second redirect to 0x200 during DRAIN makes the next address 0x200.
- **Redirect to 0x0F3 while in HOLD with i_stall_d=1:** valid clears next cycle; next request address 0x0F0.
- **Boundaries:**
  - PC 0x7FC with PC_WIDTH=10: next fetch is 0x000.
  - Force o_wait_cnt to saturation: it stays at 0xFFFF.
  - Assert reset during DRAIN: all outputs return to reset values.
